mii_64b66b_encoder: RTL and testbench
=====================================

// Module: mii_64b66b_encoder
// PURPOSE
//  Downstream stage of the MAC/MII frame generator. Consumes its 64-bit/8-lane MII stream (data + ctrl) plus txValid.
//  Produces 66-bit BASE-R blocks (2-bit sync + 64-bit payload) for the scrambler/gearbox.
//  Runs a simplified clause-49 TX state machine; illegal sequences are replaced by error blocks and counted.
// PARAMETERS
//  ERR_CNT_WIDTH   16   width of saturating error-block counter
// PORTS
//  clk          in   1              single clock, all logic rising-edge
//  i_rst_n      in   1              asynchronous, active-low reset
//  i_valid      in   1              input column valid (driven by MII generator o_txValid)
//  i_mii_data   in   64             MII data, lane k = bits [8k+7:8k], lane 0 first on wire
//  i_mii_ctrl   in   8              MII ctrl, bit k=1 -> lane k is a control char
//  o_valid      out  1              o_tx_coded valid this cycle
//  o_tx_coded   out  66             [1:0] sync header, [65:2] payload, payload[7:0] = block type / D0
//  o_err_count  out  ERR_CNT_WIDTH  number of error blocks emitted, saturating
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_valid=0, o_tx_coded=0, o_err_count=0, state=INIT. Mid-frame reset aborts with no further output.
//  Latency: 1 cycle. Column accepted at edge N with i_valid=1 -> o_valid=1 with its block after edge N.
//  i_valid=0: state, o_tx_coded and counter hold; o_valid=0.
//  Char codes: /I/=07 -> 7'h00, /E/=FE -> 7'h1E, /S/=FB, /T/=FD.
//  Column classification (priority order):
//   D: ctrl=00.
//   S: ctrl=01 and lane0=FB. /S/ is legal only in lane 0.
//   C: ctrl=FF and every lane 07 or FE.
//   T: ctrl==(8'hFF<<k) for k=0..7, lane k=FD, lanes k+1..7 each 07 or FE.
//   E: anything else, including unknown control chars and /S/ in lane 4.
//  Encodings (sync 2'b01 for data, 2'b10 otherwise):
//   D: payload = i_mii_data.
//   C: type 1E, then 8 x 7-bit codes, lane0 lowest.
//   S: type 78, payload[63:8]=lanes1..7.
//   T(k): type {87,99,AA,B4,CC,D2,E1,FF}[k], then D0..D(k-1), then (7-k) zero pad bits, then 7-bit codes for lanes k+1..7.
//   EBLOCK: sync 10, type 1E, 8 x 7'h1E.
//  States INIT, TX_C, TX_D, TX_E. Classified column -> output, next state:
//   INIT: C -> C,TX_C | S -> S,TX_D | D/T/E -> EBLOCK,TX_E.
//   TX_C: C -> C,TX_C | S -> S,TX_D | D/T/E -> EBLOCK,TX_E.
//   TX_D: D -> D,TX_D | T -> T,TX_C | C/S/E -> EBLOCK,TX_E.
//   TX_E: C -> C,TX_C | S -> S,TX_D | D -> D,TX_D | T -> T,TX_C | E -> EBLOCK,TX_E.
//  o_err_count increments once per emitted EBLOCK; it holds at all-ones (no wrap). Cleared only by reset.
//  Back-to-back frames: T in one column and S in the next are legal (TX_D -> TX_C -> TX_D).
// TESTING
//  1. Reset then all-idle columns (ctrl FF, data 0707..07) -> o_tx_coded=66'h7A each cycle, sync 10, err_count 0.
//  2. Idle, S col (data D5555555555555FB, ctrl 01), 3 D cols, T0 col (ctrl FF, lane0 FD, rest 07):
//     -> sync10/type78/payload[63:8]=D5555555555555, then 3 sync01 blocks = data, then type 87 with zero codes, then idle.
//  3. Sweep T(k) for k=0..7 with lanes 0..k-1 = 01..k -> correct type byte, data bytes, pad=0, 7-bit 00 codes.
//  4. D column while in TX_C -> EBLOCK, err_count=1; next idle column -> 66'h7A.
//  5. i_valid toggling mid-frame -> no state change or gaps in block content.
//     Async reset asserted mid-frame -> outputs 0 immediately; INIT then D -> EBLOCK.
//  6. ERR_CNT_WIDTH=2, 5 consecutive E columns -> err_count 1,2,3,3,3.

Source files
------------

// File: rtl/mii_64b66b_encoder.sv
// mii_64b66b_encoder: packs 64-bit/8-lane MII columns into 66-bit BASE-R blocks
// Ports: clk; i_rst_n async active-low reset; i_valid/i_mii_data/i_mii_ctrl input column;
//        o_valid/o_tx_coded coded block ([1:0] sync, [65:2] payload), one cycle after acceptance;
//        o_err_count saturating count of error blocks emitted.
module mii_64b66b_encoder #(
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  input  logic [63:0]              i_mii_data,
  input  logic [7:0]               i_mii_ctrl,
  output logic                     o_valid,
  output logic [65:0]              o_tx_coded,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);
  typedef enum logic [1:0] {INIT, TX_C, TX_D, TX_E} state_t;
  localparam logic [63:0] E_PAY   = {{8{7'h1E}}, 8'h1E};
  localparam logic [63:0] T_TYPES = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};
  state_t state, state_nxt;
  logic is_d, is_s, is_c, is_t, t_ok, start_ok, data_ok, blk_err;
  logic [63:0] c_pay, t_pay;
  logic [65:0] blk;
  function automatic logic is_ic(input logic [7:0] ch);
    return ch == 8'h07 || ch == 8'hFE;
  endfunction
  function automatic logic [6:0] code7(input logic [7:0] ch);
    return ch == 8'hFE ? 7'h1E : 7'h00;
  endfunction
  // In both C and T blocks the 7-bit code for lane j sits at payload bit 8+7j,
  // so the T block is the data lanes below k overlaid with the C-style codes above k.
  always_comb begin
    is_d = i_mii_ctrl == 8'h00;
    is_s = i_mii_ctrl == 8'h01 && i_mii_data[7:0] == 8'hFB;
    is_c = i_mii_ctrl == 8'hFF;
    c_pay = {56'd0, 8'h1E};
    is_t = 1'b0;
    t_ok = 1'b0;
    t_pay = '0;
    for (int j = 0; j < 8; j++) begin
      is_c = is_c && is_ic(i_mii_data[8*j +: 8]);
      c_pay[8+7*j +: 7] = code7(i_mii_data[8*j +: 8]);
    end
    for (int k = 0; k < 8; k++) begin
      t_ok = i_mii_ctrl == (8'hFF << k) && i_mii_data[8*k +: 8] == 8'hFD;
      for (int j = k + 1; j < 8; j++) t_ok = t_ok && is_ic(i_mii_data[8*j +: 8]);
      if (t_ok) begin
        is_t = 1'b1;
        t_pay = '0;
        t_pay[7:0] = T_TYPES[8*k +: 8];
        for (int j = 0; j < k; j++) t_pay[8+8*j +: 8] = i_mii_data[8*j +: 8];
        for (int j = k + 1; j < 8; j++) t_pay[8+7*j +: 7] = code7(i_mii_data[8*j +: 8]);
      end
    end
    start_ok = state != TX_D;
    data_ok = state == TX_D || state == TX_E;
    blk_err = 1'b0;
    state_nxt = TX_C;
    blk = {c_pay, 2'b10};
    if (is_c && start_ok) begin
      blk = {c_pay, 2'b10};
      state_nxt = TX_C;
    end else if (is_s && start_ok) begin
      blk = {i_mii_data[63:8], 8'h78, 2'b10};
      state_nxt = TX_D;
    end else if (is_d && data_ok) begin
      blk = {i_mii_data, 2'b01};
      state_nxt = TX_D;
    end else if (is_t && data_ok) begin
      blk = {t_pay, 2'b10};
      state_nxt = TX_C;
    end else begin
      blk = {E_PAY, 2'b10};
      state_nxt = TX_E;
      blk_err = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= INIT;
      o_valid <= 1'b0;
      o_tx_coded <= '0;
      o_err_count <= '0;
    end else if (i_valid) begin
      state <= state_nxt;
      o_valid <= 1'b1;
      o_tx_coded <= blk;
      if (blk_err && !(&o_err_count)) o_err_count <= o_err_count + 1'b1;
    end else begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mii_64b66b_encoder.sv
// tb_mii_64b66b_encoder: directed vectors, bit-appending reference model and literal checks
module tb_mii_64b66b_encoder;
  logic clk = 1'b0;
  logic rst_n, valid, v2, check_en;
  logic [63:0] data;
  logic [7:0] ctrl;
  logic o_valid, o_valid2;
  logic [65:0] tx, tx2;
  logic [15:0] err;
  logic [1:0] err2;
  int checks = 0;
  int errors = 0;
  int m_st;
  logic m_v;
  logic [65:0] m_blk;
  logic [15:0] m_err;
  localparam logic [65:0] IDLE_BLK = 66'h7A;
  localparam logic [65:0] EBLK = {{8{7'h1E}}, 8'h1E, 2'b10};
  localparam logic [65:0] S_BLK = {56'hD5555555555555, 8'h78, 2'b10};
  localparam logic [63:0] IDLE = {8{8'h07}};
  localparam logic [63:0] S_COL = 64'hD5555555555555FB;
  localparam logic [63:0] T0_COL = {{7{8'h07}}, 8'hFD};
  logic [7:0] ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
  mii_64b66b_encoder dut (.clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mii_data(data),
    .i_mii_ctrl(ctrl), .o_valid(o_valid), .o_tx_coded(tx), .o_err_count(err));
  mii_64b66b_encoder #(.ERR_CNT_WIDTH(2)) dut2 (.clk(clk), .i_rst_n(rst_n), .i_valid(valid & v2),
    .i_mii_data(data), .i_mii_ctrl(ctrl), .o_valid(o_valid2), .o_tx_coded(tx2), .o_err_count(err2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic void app(inout logic [63:0] p, inout int pos, input logic [63:0] v, input int n);
    for (int b = 0; b < n; b++) p[pos+b] = v[b];
    pos += n;
  endfunction
  // Classes: 0 D, 1 S, 2 C, 3 T, 4 E. States: 0 INIT, 1 TX_C, 2 TX_D, 3 TX_E.
  function automatic void model(input int st, input logic [63:0] d, input logic [7:0] c,
                                output logic [65:0] blk, output int nst, output bit e);
    logic [7:0] ln [8];
    logic [63:0] p = '0;
    int pos = 0;
    int cls = 4;
    int k = 0;
    bit ok, legal;
    for (int j = 0; j < 8; j++) ln[j] = d[8*j +: 8];
    if (c == 8'h00) cls = 0;
    else if (c == 8'h01 && ln[0] == 8'hFB) cls = 1;
    else begin
      while (k < 8 && !c[k]) k++;
      ok = 1;
      for (int j = 0; j < 8; j++) if ((j >= k) != c[j]) ok = 0;
      for (int j = k + 1; j < 8; j++) if (ln[j] != 8'h07 && ln[j] != 8'hFE) ok = 0;
      if (ok && k == 0 && (ln[0] == 8'h07 || ln[0] == 8'hFE)) cls = 2;
      else if (ok && ln[k] == 8'hFD) cls = 3;
    end
    legal = ((st != 2) && (cls == 1 || cls == 2)) || ((st == 2 || st == 3) && (cls == 0 || cls == 3));
    e = !legal;
    if (!legal) begin
      nst = 3;
      app(p, pos, 64'h1E, 8);
      for (int j = 0; j < 8; j++) app(p, pos, 64'h1E, 7);
      blk = {p, 2'b10};
    end else if (cls == 0) begin
      nst = 2;
      blk = {d, 2'b01};
    end else if (cls == 1) begin
      nst = 2;
      app(p, pos, 64'h78, 8);
      for (int j = 1; j < 8; j++) app(p, pos, {56'd0, ln[j]}, 8);
      blk = {p, 2'b10};
    end else begin
      nst = 1;
      if (cls == 2) app(p, pos, 64'h1E, 8);
      else begin
        app(p, pos, {56'd0, ttype[k]}, 8);
        for (int j = 0; j < k; j++) app(p, pos, {56'd0, ln[j]}, 8);
        app(p, pos, 64'd0, 7 - k);
      end
      for (int j = (cls == 2 ? 0 : k + 1); j < 8; j++) app(p, pos, ln[j] == 8'hFE ? 64'h1E : 64'h0, 7);
      blk = {p, 2'b10};
    end
  endfunction
  always @(posedge clk or negedge rst_n) begin
    logic [65:0] b;
    int n;
    bit e;
    if (!rst_n) begin
      m_st = 0; m_v = 0; m_blk = '0; m_err = '0;
    end else if (valid) begin
      model(m_st, data, ctrl, b, n, e);
      m_st = n; m_v = 1; m_blk = b;
      if (e && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end else m_v = 0;
  end
  always @(negedge clk) if (check_en) begin
    chk("model_valid", {65'd0, o_valid}, {65'd0, m_v});
    chk("model_block", tx, m_blk);
    chk("model_errcnt", {50'd0, err}, {50'd0, m_err});
  end
  task automatic col(input logic v, input logic [63:0] d, input logic [7:0] c);
    @(negedge clk);
    valid = v; data = d; ctrl = c;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] tcol(input int k);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = j < k ? 8'(j + 1) : (j == k ? 8'hFD : 8'h07);
    return r;
  endfunction
  initial begin
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [63:0] e_col [5] = '{64'h000000FB_00000000, 64'h00000000_0000009C, 64'h000000FB_00000000,
                               64'h07070707_070707FB, 64'h00000000_0000009C};
    logic [7:0] e_ctl [5] = '{8'h10, 8'h01, 8'h10, 8'hFE, 8'h01};
    rst_n = 0; valid = 0; v2 = 0; data = '0; ctrl = '0; check_en = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {65'd0, o_valid}, 66'd0);
    chk("reset_block", tx, 66'd0);
    chk("reset_errcnt", {50'd0, err}, 66'd0);
    rst_n = 1;
    check_en = 1;
    repeat (3) begin
      col(1, IDLE, 8'hFF);
      chk("idle_block", tx, IDLE_BLK);
    end
    col(1, S_COL, 8'h01);
    chk("start_block", tx, S_BLK);
    for (int i = 0; i < 3; i++) begin
      col(1, 64'h1122334455667788 + 64'(i), 8'h00);
      chk("data_block", tx, {64'h1122334455667788 + 64'(i), 2'b01});
    end
    col(1, T0_COL, 8'hFF);
    chk("t0_block", tx, 66'h21E);
    col(1, IDLE, 8'hFF);
    chk("idle_after_t", tx, IDLE_BLK);
    for (int k = 0; k < 8; k++) begin
      col(1, S_COL, 8'h01);
      col(1, tcol(k), 8'hFF << k);
      chk("t_type", {58'd0, tx[9:2]}, {58'd0, ttype[k]});
      if (k == 3) chk("t3_block", tx, {32'd0, 24'h030201, 8'hB4, 2'b10});
      if (k == 7) chk("t7_block", tx, {56'h07060504030201, 8'hFF, 2'b10});
    end
    col(1, IDLE, 8'hFF);
    col(1, 64'h0123456789ABCDEF, 8'h00);
    chk("d_in_txc", tx, EBLK);
    chk("d_in_txc_cnt", {50'd0, err}, 66'd1);
    col(1, IDLE, 8'hFF);
    chk("idle_after_e", tx, IDLE_BLK);
    col(1, S_COL, 8'h01);
    col(0, 64'hAAAA, 8'h00);
    chk("gap_valid", {65'd0, o_valid}, 66'd0);
    chk("gap_hold", tx, S_BLK);
    col(1, 64'hAAAA, 8'h00);
    chk("gap_data", tx, {64'hAAAA, 2'b01});
    col(0, 64'hBBBB, 8'h00);
    col(1, 64'hBBBB, 8'h00);
    chk("gap_data2", tx, {64'hBBBB, 2'b01});
    col(1, T0_COL, 8'hFF);
    chk("gap_t0", tx, 66'h21E);
    col(1, S_COL, 8'h01);
    col(1, 64'hCCCC, 8'h00);
    #2;
    rst_n = 0;
    valid = 0;
    #1;
    chk("async_valid", {65'd0, o_valid}, 66'd0);
    chk("async_block", tx, 66'd0);
    chk("async_errcnt", {50'd0, err}, 66'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    col(1, 64'hDDDD, 8'h00);
    chk("init_d", tx, EBLK);
    chk("init_d_cnt", {50'd0, err}, 66'd1);
    col(1, IDLE, 8'hFF);
    chk("idle_after_init_e", tx, IDLE_BLK);
    v2 = 1;
    for (int i = 0; i < 5; i++) begin
      col(1, e_col[i], e_ctl[i]);
      chk("sat_cnt", {64'd0, err2}, {64'd0, exp2[i]});
      chk("e_block", tx, EBLK);
    end
    v2 = 0;
    col(1, IDLE, 8'hFF);
    chk("final_idle", tx, IDLE_BLK);
    col(0, IDLE, 8'hFF);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
